// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv
// Description : Iterative HI/LO multiply/divide unit for the MIPS datapath.
//               Executes MULT/MULTU/DIV/DIVU over several cycles and
//               MTHI/MTLO in one; holds architectural HI/LO.
//               Ports:
//                 clk, reset (async, active-low)
//                 opcode/a/b/valid_in : request, accepted when ready_out
//                 abort               : flush in-flight operation
//                 ready_out/busy      : idle / stall indication
//                 valid_out/div_zero  : one-cycle completion pulses
//                 hi_reg/lo_reg       : architectural HI and LO
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv #(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid_in,
    input  logic             abort,
    output logic             ready_out,
    output logic             busy,
    output logic             valid_out,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_reg,
    output logic [WIDTH-1:0] lo_reg
);

    localparam logic [5:0] c_op_mthi  = 6'b010001;
    localparam logic [5:0] c_op_mtlo  = 6'b010011;
    localparam logic [5:0] c_op_mult  = 6'b011000;
    localparam logic [5:0] c_op_multu = 6'b011001;
    localparam logic [5:0] c_op_div   = 6'b011010;
    localparam logic [5:0] c_op_divu  = 6'b011011;

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t                 state_q,   state_d;
    logic [WIDTH-1:0]       hi_q,      hi_d;
    logic [WIDTH-1:0]       lo_q,      lo_d;
    logic                   valid_q,   valid_d;
    logic                   dz_q,      dz_d;
    logic                   dz_pend_q, dz_pend_d;
    logic                   is_div_q,  is_div_d;
    logic                   q_neg_q,   q_neg_d;
    logic                   r_neg_q,   r_neg_d;
    logic [2*WIDTH-1:0]     acc_q,     acc_d;     // MUL: product; DIV: {rem, dividend/quotient}
    logic [2*WIDTH-1:0]     mcand_q,   mcand_d;   // MUL: shifted multiplicand; DIV: divisor in low half
    logic [WIDTH-1:0]       mplier_q,  mplier_d;
    logic [c_cnt_w-1:0]     count_q,   count_d;

    // Operand magnitudes for the signed variants
    logic                   w_is_signed;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [2*WIDTH-1:0]     w_fast_prod;

    assign w_is_signed = (opcode == c_op_mult) || (opcode == c_op_div);
    assign w_a_neg     = w_is_signed & a[WIDTH-1];
    assign w_b_neg     = w_is_signed & b[WIDTH-1];
    assign w_mag_a     = w_a_neg ? -a : a;
    assign w_mag_b     = w_b_neg ? -b : b;

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // One shift-add multiply step
    logic [2*WIDTH-1:0]     w_mul_next;
    assign w_mul_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // One restoring divide step. The partial remainder shifted left with the
    // next dividend bit needs WIDTH+1 bits; the difference always fits WIDTH.
    logic [WIDTH:0]         w_rem_top;
    logic                   w_rem_ge;
    logic [WIDTH-1:0]       w_rem_sub;
    logic [2*WIDTH-1:0]     w_div_next;
    assign w_rem_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_rem_ge   = w_rem_top >= {1'b0, mcand_q[WIDTH-1:0]};
    assign w_rem_sub  = w_rem_top[WIDTH-1:0] - mcand_q[WIDTH-1:0];
    assign w_div_next = w_rem_ge ? {w_rem_sub, acc_q[WIDTH-2:0], 1'b1}
                                 : {w_rem_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    // Sign correction applied in the final cycle
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_quot_fix;
    logic [WIDTH-1:0]       w_rem_fix;
    assign w_prod_fix = q_neg_q ? -acc_q : acc_q;
    assign w_quot_fix = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem_fix  = r_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        valid_d   = 1'b0;
        dz_d      = 1'b0;
        dz_pend_d = dz_pend_q;
        is_div_d  = is_div_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in && !abort) begin
                    case (opcode)
                        c_op_mthi: begin
                            hi_d    = a;
                            valid_d = 1'b1;
                        end
                        c_op_mtlo: begin
                            lo_d    = a;
                            valid_d = 1'b1;
                        end
                        c_op_mult, c_op_multu: begin
                            q_neg_d   = w_a_neg ^ w_b_neg;
                            r_neg_d   = w_a_neg;
                            is_div_d  = 1'b0;
                            dz_pend_d = 1'b0;
                            mcand_d   = {{WIDTH{1'b0}}, w_mag_a};
                            mplier_d  = w_mag_b;
                            count_d   = c_cnt_init;
                            if (FAST_MUL != 0) begin
                                acc_d   = w_fast_prod;
                                state_d = S_FIX;
                            end else begin
                                acc_d   = '0;
                                state_d = S_MUL;
                            end
                        end
                        c_op_div, c_op_divu: begin
                            if (b == '0) begin
                                // Reuse the product write-back path: {hi,lo} = {a, all ones}
                                acc_d     = {a, {WIDTH{1'b1}}};
                                q_neg_d   = 1'b0;
                                r_neg_d   = 1'b0;
                                is_div_d  = 1'b0;
                                dz_pend_d = 1'b1;
                                state_d   = S_FIX;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, w_mag_a};
                                mcand_d   = {{WIDTH{1'b0}}, w_mag_b};
                                q_neg_d   = w_a_neg ^ w_b_neg;
                                r_neg_d   = w_a_neg;
                                is_div_d  = 1'b1;
                                dz_pend_d = 1'b0;
                                count_d   = c_cnt_init;
                                state_d   = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = w_mul_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - c_cnt_one;
                if (count_q == c_cnt_one) begin
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                acc_d   = w_div_next;
                count_d = count_q - c_cnt_one;
                if (count_q == c_cnt_one) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quot_fix;
                end else begin
                    {hi_d, lo_d} = w_prod_fix;
                end
                valid_d = 1'b1;
                dz_d    = dz_pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush wins over completion: drop the operation without touching HI/LO
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            valid_d = 1'b0;
            dz_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            valid_q   <= 1'b0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
            is_div_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            valid_q   <= valid_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
            is_div_q  <= is_div_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
        end
    end

    assign ready_out = (state_q == S_IDLE);
    assign busy      = ~ready_out;
    assign valid_out = valid_q;
    assign div_zero  = dz_q;
    assign hi_reg    = hi_q;
    assign lo_reg    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_muldiv
// Description : Self-checking bench for mips_cpu_muldiv (WIDTH=32). An
//               iterative instance and a FAST_MUL instance share stimulus.
//               Expected HI/LO come from 64-bit integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_muldiv;

    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        valid_in = 1'b0;
    logic        valid_in_f = 1'b0;
    logic        abort = 1'b0;
    logic        ready_out, busy, valid_out, div_zero;
    logic [31:0] hi, lo;
    logic        ready_f, busy_f, valid_f, dz_f;
    logic [31:0] hi_f, lo_f;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;   // model of architectural HI/LO of the iterative instance
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mips_cpu_muldiv #(.WIDTH(32), .FAST_MUL(0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .a(a), .b(b),
        .valid_in(valid_in), .abort(abort), .ready_out(ready_out), .busy(busy),
        .valid_out(valid_out), .div_zero(div_zero), .hi_reg(hi), .lo_reg(lo)
    );

    mips_cpu_muldiv #(.WIDTH(32), .FAST_MUL(1)) dut_f (
        .clk(clk), .reset(reset), .opcode(opcode), .a(a), .b(b),
        .valid_in(valid_in_f), .abort(abort), .ready_out(ready_f), .busy(busy_f),
        .valid_out(valid_f), .div_zero(dz_f), .hi_reg(hi_f), .lo_reg(lo_f)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: new HI/LO, div_zero and latency (edges after accept edge
    // until valid_out is seen; -1 = never) computed with plain arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit fast, inout logic [31:0] mh, inout logic [31:0] ml,
                         output logic dz, output int lat);
        longint      sp, sr;
        logic [63:0] up;
        dz  = 1'b0;
        lat = 33;
        case (op)
            OP_MTHI: begin mh = x; lat = 0; end
            OP_MTLO: begin ml = x; lat = 0; end
            OP_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {mh, ml} = sp[63:0];
                if (fast) lat = 1;
            end
            OP_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                {mh, ml} = up;
                if (fast) lat = 1;
            end
            OP_DIV, OP_DIVU: begin
                if (y == 32'd0) begin
                    ml = 32'hFFFF_FFFF; mh = x; dz = 1'b1; lat = 1;
                end else if (op == OP_DIV) begin
                    sp = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    ml = sp[31:0];
                    mh = sr[31:0];
                end else begin
                    ml = x / y;
                    mh = x % y;
                end
            end
            default: lat = -1;
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issues one request from a negedge and waits for completion. Operands are
    // scrambled right after the accept edge. held=0 if HI/LO moved early.
    task automatic run_op(input bit fast, input logic [5:0] op, input logic [31:0] x,
                          input logic [31:0] y, output int lat, output logic [31:0] rh,
                          output logic [31:0] rl, output logic rdz, output bit held);
        logic [31:0] h0, l0;
        h0 = fast ? hi_f : hi;
        l0 = fast ? lo_f : lo;
        held = 1'b1;
        lat = -1;
        rh = h0; rl = l0; rdz = 1'b0;
        opcode = op; a = x; b = y;
        if (fast) valid_in_f = 1'b1; else valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0; valid_in_f = 1'b0;
        opcode = 6'($urandom()); a = $urandom(); b = $urandom();
        for (int n = 0; n < 60; n++) begin
            if (fast ? valid_f : valid_out) begin
                lat = n;
                rh  = fast ? hi_f : hi;
                rl  = fast ? lo_f : lo;
                rdz = fast ? dz_f : div_zero;
                break;
            end
            if ((fast ? hi_f : hi) !== h0 || (fast ? lo_f : lo) !== l0) held = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({hi, lo, ready_out, busy, valid_out, div_zero} !== {64'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h rdy=%b busy=%b vo=%b dz=%b required 0 0 1 0 0 0",
                     hi, lo, ready_out, busy, valid_out, div_zero);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [5:0]  ops[6] = '{OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
        logic [31:0] xs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
        logic [31:0] ys[6]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] eh[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5};
        logic [31:0] el[6]  = '{32'd1, 32'hFFFF_FFEB, 32'd3, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        int          elat[6] = '{33, 33, 33, 33, 33, 1};
        logic        edz[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [31:0] rh, rl; logic rdz; bit held;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, ops[i], xs[i], ys[i], lat, rh, rl, rdz, held);
            checks++;
            if (lat !== elat[i] || rh !== eh[i] || rl !== el[i] || rdz !== edz[i] || !held) begin
                errors++;
                $display("FAIL directed_%0d: lat=%0d hi=%h lo=%h dz=%b held=%b required lat=%0d hi=%h lo=%h dz=%b held=1",
                         i, lat, rh, rl, rdz, held, elat[i], eh[i], el[i], edz[i]);
            end
            m_hi = eh[i]; m_lo = el[i];
        end
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_pulse_width: vo=%b dz=%b required 0 0", valid_out, div_zero);
        end
    endtask

    task automatic test_fast();
        int lat, elat; logic [31:0] rh, rl, eh, el; logic rdz, edz; bit held;
        logic [5:0] op; logic [31:0] x, y;
        for (int i = 0; i < 6; i++) begin
            op = (i == 0 || ($urandom() & 1) == 1) ? OP_MULTU : OP_MULT;
            x = (i == 0) ? 32'hFFFF_FFFF : pick();
            y = (i == 0) ? 32'hFFFF_FFFF : pick();
            eh = 32'd0; el = 32'd0;
            model(op, x, y, 1'b1, eh, el, edz, elat);
            run_op(1'b1, op, x, y, lat, rh, rl, rdz, held);
            checks++;
            if (lat !== elat || rh !== eh || rl !== el || rdz !== edz) begin
                errors++;
                $display("FAIL fast_mul_%0d op=%h a=%h b=%h: lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h",
                         i, op, x, y, lat, rh, rl, elat, eh, el);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        int lat, elat; logic [31:0] rh, rl, eh, el, x, y; logic rdz, edz; bit held;
        logic [5:0] op;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            x = pick(); y = pick();
            eh = m_hi; el = m_lo;
            model(op, x, y, 1'b0, eh, el, edz, elat);
            run_op(1'b0, op, x, y, lat, rh, rl, rdz, held);
            checks++;
            if (lat !== elat || rh !== eh || rl !== el || rdz !== edz || !held) begin
                errors++;
                $display("FAIL random_%0d op=%h a=%h b=%h: lat=%0d hi=%h lo=%h dz=%b held=%b required lat=%0d hi=%h lo=%h dz=%b",
                         i, op, x, y, lat, rh, rl, rdz, held, elat, eh, el, edz);
            end
            m_hi = eh; m_lo = el;
        end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rh, rl; logic rdz; bit held; int seen;
        run_op(1'b0, OP_MTHI, 32'h1234, 32'd0, lat, rh, rl, rdz, held);
        run_op(1'b0, OP_MTLO, 32'hABCD, 32'd0, lat, rh, rl, rdz, held);
        @(negedge clk);
        opcode = OP_MULT; a = 32'd5; b = 32'd6; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL busy_mid_op: busy=%b rdy=%b required 1 0", busy, ready_out);
        end
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: rdy=%b required 1", ready_out);
        end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (valid_out) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || hi !== 32'h1234 || lo !== 32'hABCD) begin
            errors++;
            $display("FAIL abort_hold: valid_pulses=%0d hi=%h lo=%h required 0 00001234 0000abcd", seen, hi, lo);
        end
        m_hi = 32'h1234; m_lo = 32'hABCD;
    endtask

    task automatic test_idle_block();
        int seen = 0;
        opcode = OP_MTHI; a = 32'hDEAD; valid_in = 1'b1; abort = 1'b1;
        @(negedge clk);
        opcode = 6'b000000; a = 32'hBEEF; abort = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (valid_out) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || hi !== m_hi || lo !== m_lo || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_abort_unknown: valid_pulses=%0d hi=%h lo=%h rdy=%b required 0 %h %h 1",
                     seen, hi, lo, ready_out, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2, eh1, el1, eh2, el2; logic edz; int elat, lat1, lat2;
        x1 = pick(); y1 = pick(); x2 = pick(); y2 = pick();
        eh1 = m_hi; el1 = m_lo;
        model(OP_MULT, x1, y1, 1'b0, eh1, el1, edz, elat);
        eh2 = eh1; el2 = el1;
        model(OP_MULTU, x2, y2, 1'b0, eh2, el2, edz, elat);
        lat1 = -1; lat2 = -1;
        opcode = OP_MULT; a = x1; b = y1; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opcode = OP_MULTU; a = x2; b = y2;
        for (int n = 0; n < 60; n++) begin
            if (valid_out) begin lat1 = n; break; end
            @(negedge clk);
        end
        checks++;
        if (lat1 !== 33 || hi !== eh1 || lo !== el1 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d hi=%h lo=%h rdy=%b required 33 %h %h 1", lat1, hi, lo, ready_out, eh1, el1);
        end
        @(negedge clk);
        valid_in = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (valid_out) begin lat2 = n; break; end
            @(negedge clk);
        end
        checks++;
        if (lat2 !== 33 || hi !== eh2 || lo !== el2) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d hi=%h lo=%h required 33 %h %h", lat2, hi, lo, eh2, el2);
        end
        m_hi = eh2; m_lo = el2;
    endtask

    task automatic test_reset_mid_div();
        int lat, elat; logic [31:0] rh, rl, eh, el; logic rdz, edz; bit held;
        run_op(1'b0, OP_MTHI, 32'h55, 32'd0, lat, rh, rl, rdz, held);
        run_op(1'b0, OP_MTLO, 32'h66, 32'd0, lat, rh, rl, rdz, held);
        @(negedge clk);
        opcode = OP_DIVU; a = 32'd1000; b = 32'd3; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || ready_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: hi=%h lo=%h rdy=%b busy=%b required 0 0 1 0", hi, lo, ready_out, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd0;
        eh = m_hi; el = m_lo;
        model(OP_MULT, 32'hFFFF_FF00, 32'h0001_2345, 1'b0, eh, el, edz, elat);
        run_op(1'b0, OP_MULT, 32'hFFFF_FF00, 32'h0001_2345, lat, rh, rl, rdz, held);
        checks++;
        if (lat !== elat || rh !== eh || rl !== el) begin
            errors++;
            $display("FAIL mult_after_reset: lat=%0d hi=%h lo=%h required %0d %h %h", lat, rh, rl, elat, eh, el);
        end
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fast();
        test_random();
        test_abort();
        test_idle_block();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
